// File: rtl/dmem_mmio_pkg.sv
// dmem_pkg: shared constants for the data-side memory / MMIO block.
//   MMIO register offsets, STATUS bit positions, byte-lane masks.
package dmem_pkg;
   // MMIO register offsets (daddr[11:0])
   localparam logic [11:0] TXDATA = 12'h000;
   localparam logic [11:0] STATUS = 12'h004;
   localparam logic [11:0] CYCLE  = 12'h008;

   // STATUS bit positions
   localparam int FULL      = 0;
   localparam int EMPTY     = 1;
   localparam int OVF       = 2;
   localparam int IRQEN     = 3;
   localparam int COUNT_LSB = 8;

   // byte-lane write-enable masks
   localparam logic [3:0] LANE0     = 4'b0001;
   localparam logic [3:0] ALL_LANES = 4'b1111;
endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: CPU data port plus TX byte stream.
//   daddr/dwdata/dwe  : CPU -> memory (byte address, lane-replicated data, lane enables)
//   drdata            : memory -> CPU, combinational load data
//   tx_data/tx_valid  : FIFO head towards consumer
//   tx_ready          : consumer accepts head this cycle
//   irq_tx            : only with DMEM_TX_IRQ_EN, TX-empty interrupt
// master = CPU/consumer side, slave = dmem_mmio.
interface dmem_mmio_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
`ifdef DMEM_TX_IRQ_EN
   logic        irq_tx;

   modport master (output daddr, dwdata, dwe, tx_ready,
                   input  drdata, tx_data, tx_valid, irq_tx);
   modport slave  (input  daddr, dwdata, dwe, tx_ready,
                   output drdata, tx_data, tx_valid, irq_tx);
`else
   modport master (output daddr, dwdata, dwe, tx_ready,
                   input  drdata, tx_data, tx_valid);
   modport slave  (input  daddr, dwdata, dwe, tx_ready,
                   output drdata, tx_data, tx_valid);
`endif
endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// tx_fifo: synchronous byte FIFO, DEPTH entries (power of 2, >= 2).
//   push/push_data : enqueue request (ignored when full unless popping)
//   pop            : dequeue head (ignored when empty)
//   head           : registered head byte, 0 after reset
//   full/empty/count : occupancy
// Storage is reset so the head byte reads 0 out of reset.
module tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][7:0] mem;
   logic [PW-1:0]         wptr, rptr;
   logic [PW:0]           cnt;
   logic                  do_push, do_pop;

   assign full    = (cnt == (PW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   // full + pop frees the slot being written, so the push still lands
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem  <= '0;
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop)
            rptr <= rptr + 1'b1;
         cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   assign head  = mem[rptr];
   assign count = cnt;
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM with byte-lane writes plus MMIO (TX FIFO, STATUS, CYCLE).
//   clk, reset_n : clock, async active-low reset
//   bus          : dmem_mmio_if.slave (CPU data port + TX stream)
// Loads are combinational from daddr; stores commit at the rising edge.
// Optional macro DMEM_TX_IRQ_EN adds STATUS.IRQEN and registered bus.irq_tx.
module dmem_mmio
   import dmem_pkg::*;
#(
   parameter int          RAM_WORDS  = 4096,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
   input  logic      clk,
   input  logic      reset_n,
   dmem_mmio_if.slave bus
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [RAM_WORDS];
   logic [AW-1:0] idx;
   logic          mmio_sel;
   logic [11:0]   off;
   logic          wr_tx, wr_st, wr_cy, pop;
   logic          full, empty;
   logic [CW-1:0] count;
   logic [7:0]    head;
   logic          ovf;
   logic [31:0]   cyc;
   logic [31:0]   status;
   logic [31:0]   mmio_rd;
   logic          irq_en;

   assign mmio_sel = (bus.daddr[31:12] == MMIO_BASE[31:12]);
   assign off      = bus.daddr[11:0];
   // upper address bits above the RAM index alias onto the same words
   assign idx      = bus.daddr[AW+1:2];

   assign wr_tx = mmio_sel && (off == TXDATA) && ((bus.dwe & LANE0) != '0);
   assign wr_st = mmio_sel && (off == STATUS) && ((bus.dwe & LANE0) != '0);
   assign wr_cy = mmio_sel && (off == CYCLE)  && (bus.dwe == ALL_LANES);
   assign pop   = bus.tx_valid && bus.tx_ready;

   // RAM is deliberately not reset
   always_ff @(posedge clk) begin
      if (!mmio_sel)
         for (int i = 0; i < 4; i++)
            if (bus.dwe[i]) ram[idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
   end

   tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (wr_tx),
      .push_data(bus.dwdata[7:0]),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
         cyc <= '0;
      end else begin
         // push into a full FIFO with no pop drops the byte
         if (wr_tx && full && !pop)
            ovf <= 1'b1;
         else if (wr_st && bus.dwdata[OVF])
            ovf <= 1'b0;
         cyc <= wr_cy ? bus.dwdata : cyc + 32'd1;
      end
   end

`ifdef DMEM_TX_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (wr_st) irq_en <= bus.dwdata[IRQEN];
         irq_q <= irq_en && empty;
      end
   end
   assign bus.irq_tx = irq_q;
`else
   assign irq_en = 1'b0;
`endif

   always_comb begin
      status                  = '0;
      status[FULL]            = full;
      status[EMPTY]           = empty;
      status[OVF]             = ovf;
      status[IRQEN]           = irq_en;
      status[COUNT_LSB +: 4]  = 4'(count);
   end

   always_comb begin
      mmio_rd = '0;
      case (off)
         STATUS:  mmio_rd = status;
         CYCLE:   mmio_rd = cyc;
         default: mmio_rd = '0;
      endcase
   end

   assign bus.drdata   = !reset_n ? '0 : (mmio_sel ? mmio_rd : ram[idx]);
   assign bus.tx_valid = !empty;
   assign bus.tx_data  = head;
endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   localparam logic [31:0] A_TX = 32'h8000_0000;
   localparam logic [31:0] A_ST = 32'h8000_0004;
   localparam logic [31:0] A_CY = 32'h8000_0008;

   dmem_mmio_if bus ();

   dmem_mmio dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // drive one bus cycle, commit on the next rising edge, land at edge+1
   task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      bus.daddr  = a;
      bus.dwdata = d;
      bus.dwe    = we;
      @(posedge clk);
      #1;
      bus.dwe = 4'b0000;
   endtask

   task automatic test_reset();
      bus.daddr = 32'h0; bus.dwdata = 32'h0; bus.dwe = 4'b0; bus.tx_ready = 1'b0;
      #12;
      n_chk++; if (bus.drdata !== 32'h0) $display("FAIL reset_drdata got %h want %h", bus.drdata, 32'h0); else n_pass++;
      n_chk++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); else n_pass++;
      n_chk++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", bus.tx_data); else n_pass++;
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0002) $display("FAIL reset_status got %h want %h", bus.drdata, 32'h2); else n_pass++;
   endtask

   task automatic test_ram_lane();
      bus_cycle(32'h0000_0010, 32'h1122_3344, 4'b1111);
      bus.daddr = 32'h0000_0010; bus.dwdata = 32'hDDDD_DDDD; bus.dwe = 4'b0001; #1;
      // same-cycle read sees the pre-write word
      n_chk++; if (bus.drdata !== 32'h1122_3344) $display("FAIL ram_prewrite got %h want %h", bus.drdata, 32'h1122_3344); else n_pass++;
      @(posedge clk); #1; bus.dwe = 4'b0; #1;
      n_chk++; if (bus.drdata !== 32'h1122_33DD) $display("FAIL ram_lane0 got %h want %h", bus.drdata, 32'h1122_33DD); else n_pass++;
      bus_cycle(32'h0000_0010, 32'h5555_5555, 4'b1010);
      bus.daddr = 32'h0000_0010; #1;
      n_chk++; if (bus.drdata !== 32'h5522_55DD) $display("FAIL ram_lane13 got %h want %h", bus.drdata, 32'h5522_55DD); else n_pass++;
   endtask

   task automatic test_alias();
      bus_cycle(32'h0000_4010, 32'hCAFE_BABE, 4'b1111);
      bus.daddr = 32'h0000_0010; #1;
      n_chk++; if (bus.drdata !== 32'hCAFE_BABE) $display("FAIL ram_alias got %h want %h", bus.drdata, 32'hCAFE_BABE); else n_pass++;
      // MMIO hole: write ignored, reads 0, RAM untouched
      bus_cycle(32'h8000_0010, 32'h1234_5678, 4'b1111);
      bus.daddr = 32'h8000_0010; #1;
      n_chk++; if (bus.drdata !== 32'h0) $display("FAIL mmio_hole got %h want 0", bus.drdata); else n_pass++;
      bus.daddr = 32'h0000_0010; #1;
      n_chk++; if (bus.drdata !== 32'hCAFE_BABE) $display("FAIL mmio_no_ram got %h want %h", bus.drdata, 32'hCAFE_BABE); else n_pass++;
   endtask

   task automatic test_fifo_overflow();
      bus.tx_ready = 1'b0;
      bus.daddr = A_TX; bus.dwdata = 32'h0000_0001; bus.dwe = 4'b0001; #1;
      n_chk++; if (bus.tx_valid !== 1'b0) $display("FAIL push_empty_valid_early got %b want 0", bus.tx_valid); else n_pass++;
      @(posedge clk); #1; bus.dwe = 4'b0;
      n_chk++; if (bus.tx_valid !== 1'b1) $display("FAIL push_valid_next got %b want 1", bus.tx_valid); else n_pass++;
      for (int i = 2; i <= 8; i++) bus_cycle(A_TX, 32'(i), 4'b0001);
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0801) $display("FAIL status_full got %h want %h", bus.drdata, 32'h0801); else n_pass++;
      bus_cycle(A_TX, 32'h0000_0009, 4'b0001);
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0805) $display("FAIL status_ovf got %h want %h", bus.drdata, 32'h0805); else n_pass++;
      n_chk++; if (bus.tx_data !== 8'h01) $display("FAIL head_after_ovf got %h want 01", bus.tx_data); else n_pass++;
      bus.daddr = A_TX; #1;
      n_chk++; if (bus.drdata !== 32'h0) $display("FAIL txdata_read got %h want 0", bus.drdata); else n_pass++;
      bus_cycle(A_ST, 32'h0000_0004, 4'b0001);
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0801) $display("FAIL ovf_clear got %h want %h", bus.drdata, 32'h0801); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      bus.tx_ready = 1'b1;
      bus_cycle(A_TX, 32'h0000_000A, 4'b0001);
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0801) $display("FAIL full_pushpop_status got %h want %h", bus.drdata, 32'h0801); else n_pass++;
      for (int k = 1; k < 9; k++) begin
         n_chk++;
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[k])
            $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", k, bus.tx_valid, bus.tx_data, exp[k]);
         else n_pass++;
         @(posedge clk); #1;
      end
      bus.tx_ready = 1'b0; #1;
      n_chk++; if (bus.tx_valid !== 1'b0) $display("FAIL drained_valid got %b want 0", bus.tx_valid); else n_pass++;
      n_chk++; if (bus.drdata !== 32'h0000_0002) $display("FAIL drained_status got %h want %h", bus.drdata, 32'h2); else n_pass++;
   endtask

   task automatic test_cycle();
      bus_cycle(A_CY, 32'hFFFF_FFFE, 4'b1111);
      bus.daddr = A_CY; #1;
      n_chk++; if (bus.drdata !== 32'hFFFF_FFFE) $display("FAIL cycle_load got %h want %h", bus.drdata, 32'hFFFF_FFFE); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.drdata !== 32'hFFFF_FFFF) $display("FAIL cycle_inc got %h want %h", bus.drdata, 32'hFFFF_FFFF); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.drdata !== 32'h0) $display("FAIL cycle_wrap got %h want 0", bus.drdata); else n_pass++;
      bus_cycle(A_CY, 32'h1234_5678, 4'b0011);
      bus.daddr = A_CY; #1;
      n_chk++; if (bus.drdata !== 32'h1) $display("FAIL cycle_partial got %h want 1", bus.drdata); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) bus_cycle(A_TX, 32'h20 + 32'(i), 4'b0001);
      bus.tx_ready = 1'b1;
      @(posedge clk); #1;
      bus.tx_ready = 1'b0;
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0302) begin
         if (bus.drdata !== 32'h0000_0300) $display("FAIL mid_count got %h want %h", bus.drdata, 32'h0300); else n_pass++;
      end else $display("FAIL mid_count got %h want %h", bus.drdata, 32'h0300);
      n_chk++; if (bus.tx_data !== 8'h22) $display("FAIL mid_head got %h want 22", bus.tx_data); else n_pass++;
      bus.daddr = 32'h0000_0010;
      #1 reset_n = 1'b0;
      #1;
      n_chk++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", bus.tx_valid); else n_pass++;
      n_chk++; if (bus.drdata !== 32'h0) $display("FAIL mid_reset_drdata got %h want 0", bus.drdata); else n_pass++;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      bus.daddr = A_ST; #1;
      n_chk++; if (bus.drdata !== 32'h0000_0002) $display("FAIL post_reset_status got %h want %h", bus.drdata, 32'h2); else n_pass++;
      bus.daddr = A_CY; #1;
      n_chk++; if (bus.drdata !== 32'h1) $display("FAIL post_reset_cycle got %h want 1", bus.drdata); else n_pass++;
      bus.daddr = 32'h0000_0010; #1;
      n_chk++; if (bus.drdata !== 32'hCAFE_BABE) $display("FAIL ram_kept got %h want %h", bus.drdata, 32'hCAFE_BABE); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ram_lane();
      test_alias();
      test_fifo_overflow();
      test_full_push_pop();
      test_cycle();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
